// File: rtl/ul_bbu_pack_pkg.sv
// Shared types for the uplink BBU packer: write-side FSM states and FIFO entry layout.
// Entry layout is {fram_flag, last_flag, data[31:0]}.
package ul_bbu_pack_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DROP = 2'd2
  } state_t;

  localparam int ENTRY_W  = 34;
  localparam int FRAM_BIT = 33;
  localparam int LAST_BIT = 32;

  function automatic logic [ENTRY_W-1:0] pack_entry(input logic fram,
                                                     input logic last,
                                                     input logic [31:0] data);
    return {fram, last, data};
  endfunction

endpackage

// File: rtl/ul_bbu_pack_fifo.sv
// Synchronous first-word-fall-through FIFO with a free-slot count from registered pointers.
// Pointers carry one spare wrap bit so full and empty are distinguishable; reset flushes contents.
module ul_bbu_pack_fifo #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 34
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_wr,
  input  logic [WIDTH-1:0]           i_wdata,
  input  logic                       i_rd,
  output logic [WIDTH-1:0]           o_rdata,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_free
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [AW:0]      w_count;

  assign w_count = r_wr_ptr - r_rd_ptr;
  assign o_empty = (w_count == '0);
  assign o_free  = DEPTH_W - w_count;
  assign o_rdata = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (i_wr) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (i_rd && !o_empty) r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  // Storage is deliberately not reset; validity is tracked by the pointers alone.
  always_ff @(posedge clk) begin
    if (i_wr) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
  end

endmodule

// File: rtl/ul_bbu_pack.sv
// Uplink BBU packer: registers the IQ stream, admits whole antenna groups into a FWFT FIFO, drops and counts groups that do not fit.
// Optional frame counter enabled by defining UL_BBU_PACK_FRAMCNT_EN; 2-clock minimum latency, output held stable under back-pressure.
module ul_bbu_pack
  import ul_bbu_pack_pkg::*;
#(
  parameter int DEPTH   = 64,
  parameter int ANT_NUM = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_en,
  input  logic        i_fram_hd,
  input  logic        i_ant8_sel,
  input  logic [31:0] i_data,
  output logic [31:0] o_tdata,
  output logic        o_tvalid,
  input  logic        i_tready,
  output logic        o_tlast,
  output logic        o_tuser,
  output logic [15:0] o_ovf_cnt,
  output logic [15:0] o_fram_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = $clog2(ANT_NUM + 1);
  localparam logic [AW:0]   FREE_MIN = (AW+1)'(ANT_NUM);
  localparam logic [PW-1:0] LAST_POS = PW'(ANT_NUM - 1);
  localparam logic [PW-1:0] POS_SAT  = PW'(ANT_NUM);

  logic               r_en, r_fram_hd, r_ant8_sel;
  logic [31:0]        r_data;
  state_t             r_state;
  logic [PW-1:0]      r_pos;
  logic [15:0]        r_ovf_cnt;

  state_t             w_next;
  logic               w_wr, w_drop, w_fits, w_empty, w_rd;
  logic [PW-1:0]      w_pos;
  logic [AW:0]        w_free;
  logic [ENTRY_W-1:0] w_entry, w_head;

  assign w_fits  = (w_free >= FREE_MIN);
  assign w_pos   = r_ant8_sel ? '0 : r_pos;
  assign w_entry = pack_entry(r_fram_hd, (w_pos == LAST_POS), r_data);

  // Admission is decided only at group starts, so a group is either kept whole or dropped whole.
  always_comb begin
    w_next = r_state;
    w_wr   = 1'b0;
    w_drop = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_ant8_sel && r_fram_hd && r_en) begin
          if (w_fits) begin
            w_next = RUN;
            w_wr   = 1'b1;
          end else begin
            w_next = DROP;
            w_drop = 1'b1;
          end
        end
      end
      RUN, DROP: begin
        if (r_ant8_sel) begin
          if (!r_en) begin
            w_next = IDLE;
          end else if (w_fits) begin
            w_next = RUN;
            w_wr   = 1'b1;
          end else begin
            w_next = DROP;
            w_drop = 1'b1;
          end
        end else if (r_state == RUN) begin
          w_wr = (w_free != '0);
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_en       <= 1'b0;
      r_fram_hd  <= 1'b0;
      r_ant8_sel <= 1'b0;
      r_data     <= '0;
      r_state    <= IDLE;
      r_pos      <= '0;
      r_ovf_cnt  <= '0;
    end else begin
      r_en       <= i_en;
      r_fram_hd  <= i_fram_hd;
      r_ant8_sel <= i_ant8_sel;
      r_data     <= i_data;
      r_state    <= w_next;
      r_pos      <= (w_pos != POS_SAT) ? w_pos + PW'(1) : w_pos;
      if (w_drop && r_ovf_cnt != 16'hFFFF) r_ovf_cnt <= r_ovf_cnt + 16'd1;
    end
  end

  assign o_ovf_cnt = r_ovf_cnt;

`ifdef UL_BBU_PACK_FRAMCNT_EN
  logic [15:0] r_fram_cnt;
  always_ff @(posedge clk) begin
    if (rst) r_fram_cnt <= '0;
    else if (w_wr && r_fram_hd) r_fram_cnt <= r_fram_cnt + 16'd1;
  end
  assign o_fram_cnt = r_fram_cnt;
`else
  assign o_fram_cnt = 16'd0;
`endif

  assign w_rd = o_tvalid & i_tready;

  ul_bbu_pack_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_wr    (w_wr),
    .i_wdata (w_entry),
    .i_rd    (w_rd),
    .o_rdata (w_head),
    .o_empty (w_empty),
    .o_free  (w_free)
  );

  // Head is masked while empty so the reset and idle output is all zero.
  assign o_tvalid = !w_empty;
  assign o_tdata  = w_empty ? 32'd0 : w_head[31:0];
  assign o_tlast  = !w_empty && w_head[LAST_BIT];
  assign o_tuser  = !w_empty && w_head[FRAM_BIT];

endmodule

// File: tb/tb_ul_bbu_pack.sv
// Bench for ul_bbu_pack: directed stimulus pushes expected {tuser,tlast,data} into a queue,
// a forked monitor pops and compares on every accepted output beat.
module tb_ul_bbu_pack;

  logic        clk = 1'b0;
  logic        rst, i_en, i_fram_hd, i_ant8_sel, i_tready;
  logic [31:0] i_data;
  logic [31:0] o_tdata;
  logic        o_tvalid, o_tlast, o_tuser;
  logic [15:0] o_ovf_cnt, o_fram_cnt;

  logic [33:0] sb[$];
  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  ul_bbu_pack #(.DEPTH(64), .ANT_NUM(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_en       (i_en),
    .i_fram_hd  (i_fram_hd),
    .i_ant8_sel (i_ant8_sel),
    .i_data     (i_data),
    .o_tdata    (o_tdata),
    .o_tvalid   (o_tvalid),
    .i_tready   (i_tready),
    .o_tlast    (o_tlast),
    .o_tuser    (o_tuser),
    .o_ovf_cnt  (o_ovf_cnt),
    .o_fram_cnt (o_fram_cnt)
  );

  task automatic chk(input string name, input logic [33:0] act, input logic [33:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic en, input logic fh, input logic gs,
                       input logic [31:0] d, input bit exp, input bit last);
    @(posedge clk); #1;
    i_en = en; i_fram_hd = fh; i_ant8_sel = gs; i_data = d;
    if (exp) sb.push_back({fh, last, d});
  endtask

  task automatic send_group(input logic en, input logic fh, input logic [31:0] base, input bit exp);
    for (int i = 0; i < 4; i++)
      drive(en, fh && (i == 0), i == 0, base + 32'(i), exp, i == 3);
  endtask

  task automatic end_stream();
    drive(1'b0, 1'b0, 1'b1, 32'hEEEE_EEEE, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic set_ready(input logic r);
    @(posedge clk); #1;
    i_tready = r;
  endtask

  task automatic drain(input string name);
    int cyc = 0;
    while ((sb.size() != 0 || o_tvalid) && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    chk({name, "_drained"}, 34'(sb.size()), 34'd0);
  endtask

  task automatic do_reset(input int cycles);
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (cycles) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; i_en = 1'b0; i_fram_hd = 1'b0; i_ant8_sel = 1'b0;
    i_data = 32'h0; i_tready = 1'b1;

    fork
      forever begin
        @(negedge clk);
        if (!rst && o_tvalid && i_tready) begin
          if (sb.size() == 0) begin
            chk("unexpected_beat", {o_tuser, o_tlast, o_tdata}, 34'h3_FFFF_FFFF);
          end else begin
            logic [33:0] e;
            e = sb.pop_front();
            chk("beat", {o_tuser, o_tlast, o_tdata}, e);
          end
        end
      end
    join_none

    // Reset state
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_tvalid", 34'(o_tvalid), 34'd0);
    chk("rst_tdata", 34'(o_tdata), 34'd0);
    chk("rst_tlast", 34'(o_tlast), 34'd0);
    chk("rst_tuser", 34'(o_tuser), 34'd0);
    chk("rst_ovf", 34'(o_ovf_cnt), 34'd0);
    chk("rst_fram", 34'(o_fram_cnt), 34'd0);

    // Steady state frame 0..31, with 2-clock latency on the first word
    drive(1'b1, 1'b1, 1'b1, 32'd0, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 32'd1, 1'b1, 1'b0);
    @(negedge clk);
    chk("lat_not_yet", 34'(o_tvalid), 34'd0);
    drive(1'b1, 1'b0, 1'b0, 32'd2, 1'b1, 1'b0);
    @(negedge clk);
    chk("lat_first", {1'b0, o_tvalid, o_tdata}, {2'b01, 32'd0});
    drive(1'b1, 1'b0, 1'b0, 32'd3, 1'b1, 1'b1);
    for (int g = 1; g < 8; g++) send_group(1'b1, 1'b0, 32'(4 * g), 1'b1);
    end_stream();
    drain("steady");
    chk("steady_ovf", 34'(o_ovf_cnt), 34'd0);

    // Group starts without a header in IDLE are ignored
    for (int g = 0; g < 3; g++) send_group(1'b1, 1'b0, 32'(100 + 4 * g), 1'b0);
    @(negedge clk);
    chk("idle_no_out", 34'(o_tvalid), 34'd0);
    send_group(1'b1, 1'b1, 32'd200, 1'b1);
    send_group(1'b1, 1'b0, 32'd204, 1'b1);
    end_stream();
    drain("idle_hdr");

    // Back-pressure overflow: 25 groups, 16 admitted, 9 dropped
    set_ready(1'b0);
    for (int g = 0; g < 25; g++) send_group(1'b1, g == 0, 32'(1000 + 4 * g), g < 16);
    end_stream();
    @(negedge clk);
    chk("stall_head", {o_tuser, o_tlast, o_tdata}, {2'b10, 32'd1000});
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("stall_hold", {o_tuser, o_tvalid, o_tdata}, {2'b11, 32'd1000});
    chk("ovf_cnt", 34'(o_ovf_cnt), 34'd9);
    set_ready(1'b1);
    drain("ovf");

    // Reset mid-frame with FIFO half full flushes everything
    set_ready(1'b0);
    send_group(1'b1, 1'b1, 32'd2000, 1'b0);
    for (int g = 1; g < 8; g++) send_group(1'b1, 1'b0, 32'(2000 + 4 * g), 1'b0);
    @(negedge clk);
    chk("pre_rst_valid", 34'(o_tvalid), 34'd1);
    do_reset(1);
    @(negedge clk);
    chk("post_rst_valid", 34'(o_tvalid), 34'd0);
    chk("post_rst_ovf", 34'(o_ovf_cnt), 34'd0);
    chk("post_rst_fram", 34'(o_fram_cnt), 34'd0);
    set_ready(1'b1);
    send_group(1'b1, 1'b0, 32'd2100, 1'b0);
    send_group(1'b1, 1'b0, 32'd2104, 1'b0);
    @(negedge clk);
    chk("post_rst_idle", 34'(o_tvalid), 34'd0);
    send_group(1'b1, 1'b1, 32'd3000, 1'b1);
    end_stream();
    drain("rst");

    // i_en dropped mid group 2: group 2 completes, then nothing until en and header
    send_group(1'b1, 1'b1, 32'd4000, 1'b1);
    drive(1'b1, 1'b0, 1'b1, 32'd4004, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 32'd4005, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 32'd4006, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 32'd4007, 1'b1, 1'b1);
    send_group(1'b0, 1'b0, 32'd4008, 1'b0);
    send_group(1'b0, 1'b1, 32'd4012, 1'b0);
    send_group(1'b1, 1'b0, 32'd4016, 1'b0);
    send_group(1'b1, 1'b1, 32'd4100, 1'b1);
    end_stream();
    drain("en_drop");

    // Frame counter: 3 frames after a fresh reset
    do_reset(2);
    for (int f = 0; f < 3; f++) begin
      send_group(1'b1, 1'b1, 32'(5000 + 16 * f), 1'b1);
      send_group(1'b1, 1'b0, 32'(5004 + 16 * f), 1'b1);
    end
    end_stream();
    drain("fram");
`ifdef UL_BBU_PACK_FRAMCNT_EN
    chk("fram_cnt", 34'(o_fram_cnt), 34'd3);
`else
    chk("fram_cnt", 34'(o_fram_cnt), 34'd0);
`endif
    chk("fram_ovf", 34'(o_ovf_cnt), 34'd0);

    disable fork;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/ul_bbu_pack.md
# ul_bbu_pack

Uplink BBU-side packer sitting directly downstream of the uplink datapath interface (after the AGC stage). It takes the continuous one-word-per-clock IQ stream (frame header pulse, antenna-group marker, 32-bit data) and buffers it in a synchronous FIFO. It then presents it to the BBU link as a valid/ready stream with group-last and frame-start flags. When the BBU back-pressures long enough to exhaust the buffer, whole antenna groups are dropped and counted, never partial groups.

## Interface
- DEPTH, 64: FIFO depth in 32-bit words; power of 2, at least 2*ANT_NUM.
- ANT_NUM, 4: words per antenna group; the group starts on the cycle i_ant8_sel is high.
- clk  in  1  datapath clock, 245.76 MHz.
- rst  in  1  synchronous, active-high reset.
- i_en  in  1  packing enable.
- i_fram_hd  in  1  frame header pulse, coincident with a group-start word.
- i_ant8_sel  in  1  group-start marker (first word of an ANT_NUM-word group).
- i_data  in  32  IQ word, valid every cycle.
- o_tdata  out  32  output IQ word.
- o_tvalid  out  1  o_tdata valid.
- i_tready  in  1  BBU accepts the word when o_tvalid and i_tready are both high.
- o_tlast  out  1  last word of a group.
- o_tuser  out  1  first word of a frame (carried i_fram_hd).
- o_ovf_cnt  out  16  dropped-group count, saturating.
- o_fram_cnt  out  16  accepted-frame count; see Configuration.

## Operation
- Write-side FSM states:
  - IDLE: no writes. Goes to RUN on a cycle with i_en=1, i_fram_hd=1 and i_ant8_sel=1; that word is the first one written.
  - RUN: every input word is written. At each group start, the FIFO free count is checked against ANT_NUM:
    - if free < ANT_NUM, go to DROP for this group and increment o_ovf_cnt;
    - if i_en=0 at a group start, go to IDLE without writing.
  - DROP: discard words until the next group start, then apply the same group-start check as RUN.
- A group start without i_fram_hd in IDLE is ignored. A frame is only ever entered on its header.
- If i_ant8_sel arrives before ANT_NUM words of the current group, the group restarts at that word. The words already written are kept and o_tlast is not retro-set. A counter tracks the word position in the group.
- FIFO entry is 34 bits: {fram_flag, last_flag, data}. last_flag is set on word ANT_NUM-1 of the group.
- Read side is first-word-fall-through and fully independent of the FSM:
  - o_tvalid = FIFO not empty;
  - pop on o_tvalid & i_tready;
  - o_tdata, o_tlast and o_tuser are driven from the FIFO head.
- The free count is computed from registered pointers with a one-spare-bit wrap. A simultaneous write and pop leaves occupancy unchanged.
- o_ovf_cnt saturates at 16'hFFFF.

## Timing
- Input is registered once; the FIFO write happens on the next edge.
- Minimum latency is 2 clocks: i_data at cycle n appears on o_tdata at n+2 when the FIFO is empty.
- Reset values:
  - o_tvalid=0, o_tdata=0, o_tlast=0, o_tuser=0;
  - o_ovf_cnt=0, o_fram_cnt=0;
  - FSM in IDLE, pointers 0.
- Reset mid-operation flushes the FIFO contents on the same edge. o_tvalid is low in the cycle after rst.
- Full: no write ever occurs with free=0, because a group is admitted only if the whole group fits.
- Empty with a write in the same cycle: o_tvalid rises the following cycle; there is no bypass.
- While o_tvalid=1 and i_tready=0, o_tdata, o_tlast and o_tuser must stay stable.
- i_en falling mid-group: the current group completes, and the FSM enters IDLE at the next group start.

## Configuration
- UL_BBU_PACK_FRAMCNT_EN:
  - defined: o_fram_cnt increments (wrapping at 16 bits) on each accepted word written with fram_flag=1;
  - undefined: o_fram_cnt is tied to 0 and its counter logic is absent.

## Structure
- Package ul_bbu_pack_pkg holds:
  - the FSM state enum (IDLE, RUN, DROP);
  - the FIFO entry width constant (34) and the field index constants for fram_flag and last_flag.
- Sub-module ul_bbu_pack_fifo: a synchronous first-word-fall-through FIFO, parameterised by DEPTH and width, exporting a free count. The FSM and counters stay in ul_bbu_pack.

## Test plan
- Steady state, i_tready=1, frame of 8 groups (ANT_NUM=4), data = incrementing 0..31:
  - o_tdata reproduces 0..31 starting 2 cycles after input;
  - o_tuser=1 on word 0 only;
  - o_tlast on words 3, 7, …, 31;
  - o_ovf_cnt=0.
- Start in IDLE, group starts without i_fram_hd for 3 groups, then a header: no output until the header word, which emerges with o_tuser=1.
- i_tready=0 for 100 cycles, DEPTH=64:
  - exactly 16 groups (64 words) are buffered and o_ovf_cnt ends at 9 (groups 17–25 dropped; group 16 admitted with free=4);
  - after release, output resumes with whole groups only.
- rst asserted for 1 cycle mid-frame with the FIFO half full:
  - next cycle o_tvalid=0 and counters are 0;
  - output resumes only after the next i_fram_hd.
- i_en dropped mid-group 2 of a frame: group 2 completes; nothing is written until i_en=1 and the next i_fram_hd.
- Built with UL_BBU_PACK_FRAMCNT_EN, 3 frames streamed: o_fram_cnt=3. Built without it: o_fram_cnt stays 0.
